mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_timer.sv | 34 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I-cache / D-cache main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_arb_timer.sv
// Clearable 8-bit transfer timer; tc_o flags the last permitted cycle before timeout.
module mem_arb_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [7:0] term_i,
  output logic       tc_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (inc_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted while this cycle's increment would make the count reach term_i.
  assign tc_o = (count_q == (term_i - 8'd1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter (I-cache fills, D-cache reads/writes) with transfer timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed D-cache priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ic_req_i,
  input  logic [31:0] ic_addr_i,
  input  logic        dc_req_i,
  input  logic        dc_we_i,
  input  logic [31:0] dc_addr_i,
  input  logic [31:0] dc_wdata_i,
  output logic        ic_done_o,
  output logic        dc_done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  localparam logic [7:0] TERM = 8'(TIMEOUT_CYCLES);

  state_e      state_q,  state_d;
  req_id_e     winner_q, winner_d;
  logic [31:0] addr_q,   addr_d;
  logic        we_q,     we_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [31:0] rdata_q,  rdata_d;
  logic        err_q,    err_d;
  logic        sel_dc;
  logic        timer_tc;

`ifdef MEM_ARB_RR_EN
  // Points at the requester that wins the next contention.
  req_id_e     ptr_q, ptr_d;

  assign sel_dc = dc_req_i && (!ic_req_i || (ptr_q == REQ_DC));
`else
  assign sel_dc = dc_req_i;
`endif

  mem_arb_timer u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_q != ST_XFER),
    .inc_i  ((state_q == ST_XFER) && !mem_ack_i),
    .term_i (TERM),
    .tc_o   (timer_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      winner_q <= REQ_DC;
      addr_q   <= 32'd0;
      we_q     <= 1'b0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      ptr_q    <= REQ_DC;
`endif
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef MEM_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef MEM_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ic_req_i || dc_req_i) begin
          state_d  = ST_XFER;
          winner_d = sel_dc ? REQ_DC : REQ_IC;
          addr_d   = sel_dc ? dc_addr_i : ic_addr_i;
          we_d     = sel_dc && dc_we_i;
          wdata_d  = sel_dc ? dc_wdata_i : 32'd0;
          err_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
          ptr_d    = sel_dc ? REQ_IC : REQ_DC;
`endif
        end
      end
      ST_XFER: begin
        // An ack arriving on the terminal cycle still completes cleanly.
        if (mem_ack_i) begin
          if (!we_q) begin
            rdata_d = mem_rdata_i;
          end
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (timer_tc) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    mem_req_o   = (state_q == ST_XFER);
    mem_we_o    = (state_q == ST_XFER) && we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    ic_done_o   = (state_q == ST_DONE) && (winner_q == REQ_IC);
    dc_done_o   = (state_q == ST_DONE) && (winner_q == REQ_DC);
    err_o       = (state_q == ST_DONE) && err_q;
    rdata_o     = rdata_q;
  end

endmodule
